// File: rtl/writeback_trap.sv
// writeback_trap
//   Final pipeline stage. Selects register-file and CSR write data, arbitrates
//   pending interrupts against the exception carried from memory, holds the
//   core in a WFI sleep state until an interrupt wakes it, counts retired
//   instructions and supplies the trap PC / cause.
//
// Ports
//   clk, reset                 clock, synchronous active-high reset
//   valid_in                   instruction present from memory
//   pc_in, next_pc_in          PC of instruction and of its successor
//   alu/csr/load_data_in       result sources
//   write_select_in            00 alu, 01 csr, 10 load, 11 next_pc
//   rd_address_in              destination register
//   csr_address_in             CSR address
//   csr_write_in, mret_in,
//   wfi_in                     instruction flags
//   exception_in, ecause_in    memory-stage exception and its cause
//   irq_pending                masked interrupt lines, higher index wins
//   rd_address, rd_data        regfile write (address 0 = no write)
//   csr_write, csr_address,
//   csr_data                   CSR write port
//   traped, mret               trap taken / mret executed this cycle
//   sleeping                   core held in WFI
//   retired                    instruction retired this cycle
//   ecp, ecause, interupt      trap return PC, cause, interrupt flag
//   instret                    retired-instruction counter
module writeback_trap #(
   parameter int unsigned          XLEN       = 32,
   parameter int unsigned          NUM_IRQ    = 3,
   parameter logic [4*NUM_IRQ-1:0] IRQ_CAUSES = {4'd11, 4'd7, 4'd3},
   parameter int unsigned          CNT_WIDTH  = 64
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 valid_in,
   input  logic [XLEN-1:0]      pc_in,
   input  logic [XLEN-1:0]      next_pc_in,
   input  logic [XLEN-1:0]      alu_data_in,
   input  logic [XLEN-1:0]      csr_data_in,
   input  logic [XLEN-1:0]      load_data_in,
   input  logic [1:0]           write_select_in,
   input  logic [4:0]           rd_address_in,
   input  logic [11:0]          csr_address_in,
   input  logic                 csr_write_in,
   input  logic                 mret_in,
   input  logic                 wfi_in,
   input  logic                 exception_in,
   input  logic [3:0]           ecause_in,
   input  logic [NUM_IRQ-1:0]   irq_pending,
   output logic [4:0]           rd_address,
   output logic [XLEN-1:0]      rd_data,
   output logic                 csr_write,
   output logic [11:0]          csr_address,
   output logic [XLEN-1:0]      csr_data,
   output logic                 traped,
   output logic                 mret,
   output logic                 sleeping,
   output logic                 retired,
   output logic [XLEN-1:0]      ecp,
   output logic [3:0]           ecause,
   output logic                 interupt,
   output logic [CNT_WIDTH-1:0] instret
);

   localparam logic [0:0] RUN   = 1'b0;
   localparam logic [0:0] SLEEP = 1'b1;

   logic [0:0]      state;
   logic [XLEN-1:0] wake_pc;
   logic            exec;
   logic            irq_any;
   logic [3:0]      irq_cause;
   logic            commit;

   assign sleeping = (state == SLEEP);
   assign exec     = valid_in && !exception_in && !sleeping;
   assign irq_any  = |irq_pending;
   assign traped   = irq_any || (valid_in && exception_in && !sleeping);
   // commit: instruction executes and is not squashed by a trap
   assign commit   = exec && !traped;

   // Later (higher-index) lines overwrite earlier ones, giving priority.
   always_comb begin
      irq_cause = '0;
      for (int unsigned i = 0; i < NUM_IRQ; i++) begin
         if (irq_pending[i]) irq_cause = IRQ_CAUSES[4*i +: 4];
      end
   end

   always_comb begin
      ecause   = '0;
      interupt = 1'b0;
      if (irq_any) begin
         ecause   = irq_cause;
         interupt = 1'b1;
      end else if (exception_in && valid_in) begin
         ecause = ecause_in;
      end
   end

   // A wfi that traps resumes after itself, so its return PC is next_pc_in.
   assign ecp = sleeping ? wake_pc : (wfi_in ? next_pc_in : pc_in);

   always_comb begin
      rd_data = alu_data_in;
      case (write_select_in)
         2'b00: rd_data = alu_data_in;
         2'b01: rd_data = csr_data_in;
         2'b10: rd_data = load_data_in;
         2'b11: rd_data = next_pc_in;
      endcase
   end

   assign rd_address  = commit ? rd_address_in : 5'd0;
   assign csr_write   = commit && csr_write_in;
   assign csr_address = csr_address_in;
   assign csr_data    = alu_data_in;
   assign mret        = commit && mret_in;
   assign retired     = commit && !wfi_in;

   always_ff @(posedge clk) begin
      if (reset) begin
         state   <= RUN;
         wake_pc <= '0;
      end else begin
         case (state)
            RUN: begin
               if (exec && wfi_in && !irq_any) begin
                  state   <= SLEEP;
                  wake_pc <= next_pc_in;
               end
            end
            SLEEP: begin
               if (irq_any) state <= RUN;
            end
            default: state <= RUN;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (reset) instret <= '0;
      else if (retired) instret <= instret + CNT_WIDTH'(1);
   end

endmodule
